wb_xbar_1ton: RTL and testbench

Parametrised Wishbone classic 1-master-to-N-slave interconnect. It replaces hand-written per-SoC decode/stb/ack/data muxing on the core's data bus. It decodes each transfer against per-slave base/mask windows and latches the selected slave for the whole transfer. Unlike hard-coded decoders, it does not stop simulation on an unmapped access: it answers unmapped addresses and hung slaves with a Wishbone `err` and records the fault in sticky status registers.

---
 rtl/wb_xbar_1ton.sv | 167 ++++++++++++++++
 tb/tb_wb_xbar_1ton.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_xbar_1ton.sv
// Wishbone classic 1-master-to-N-slave decoder/mux with unmapped-address and timeout error reporting.
// Latency: slave strobe one cycle after the request is decoded; ack/data pass through combinationally.
// Backpressure: the master waits on ack/err; dropping cyc aborts silently; a silent slave is cut off by the timeout.
module wb_xbar_1ton #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  input  logic                             wbm_we_i,
  input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic                             wbs_we_o,
  output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  output logic                             err_pending_o,
  output logic [1:0]                       err_cause_o,
  output logic [ADDR_WIDTH-1:0]            err_adr_o,
  input  logic                             err_clr_i
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [1:0] CAUSE_UNMAP = 2'b01;
  localparam logic [1:0] CAUSE_TMO   = 2'b10;

  logic [1:0]            r_state;
  logic [SEL_W-1:0]      r_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err_pending;
  logic [1:0]            r_err_cause;
  logic [ADDR_WIDTH-1:0] r_err_adr;

  logic                  w_hit_any;
  logic [SEL_W-1:0]      w_hit_idx;
  logic                  w_sel_ack;
  logic [DATA_WIDTH-1:0] w_sel_dat;
  logic                  w_busy;
  logic                  w_req;
  logic                  w_unmapped;
  logic                  w_timeout;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_req      = wbm_cyc_i & wbm_stb_i;
  assign w_unmapped = (r_state == ST_IDLE) & w_req & ~w_hit_any;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) & w_busy & wbm_cyc_i & ~w_sel_ack & (r_cnt == CNT_LAST);

  // Address decode; scanning from the top down leaves the lowest hitting window selected.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit_any = 1'b1;
        w_hit_idx = SEL_W'(i);
      end
    end
  end

  // Pick the latched slave's ack and read data; other slaves' acks never reach the master.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_W'(i) == r_sel) begin
        w_sel_ack = wbs_ack_i[i];
        w_sel_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Slave-side steering and master-side responses; nothing is routed outside BUSY.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (w_busy) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (SEL_W'(i) == r_sel) begin
          wbs_cyc_o[i] = wbm_cyc_i;
          wbs_stb_o[i] = wbm_cyc_i & wbm_stb_i;
        end
      end
    end
    // Gated by cyc so an abort never completes, and by reset so a late slave ack is dropped.
    wbm_ack_o = w_busy & wbm_cyc_i & w_sel_ack & ~wb_rst_i;
    wbm_err_o = (r_state == ST_ERR);
    wbm_dat_o = w_busy ? w_sel_dat : '0;
  end

  assign wbs_adr_o     = wbm_adr_i;
  assign wbs_dat_o     = wbm_dat_i;
  assign wbs_we_o      = wbm_we_i;
  assign wbs_sel_o     = wbm_sel_i;
  assign err_pending_o = r_err_pending;
  assign err_cause_o   = r_err_cause;
  assign err_adr_o     = r_err_adr;

  // Transfer FSM: latch the decoded slave, track ack-less cycles, emit a one-cycle error.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit_any) begin
              r_state <= ST_BUSY;
              r_sel   <= w_hit_idx;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end
        ST_BUSY: begin
          if (!wbm_cyc_i || w_sel_ack) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_state <= ST_ERR;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky fault status; a fault detected alongside a clear keeps the flag set with the new details.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err_pending <= 1'b0;
      r_err_cause   <= 2'b00;
      r_err_adr     <= '0;
    end else if (w_unmapped || w_timeout) begin
      r_err_pending <= 1'b1;
      r_err_cause   <= w_unmapped ? CAUSE_UNMAP : CAUSE_TMO;
      r_err_adr     <= wbm_adr_i;
    end else if (err_clr_i) begin
      r_err_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_xbar_1ton.sv
// Directed bench for wb_xbar_1ton: 3 slaves, timeout 8.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Each task drives one scenario cycle by cycle against hand-computed expectations.
module tb_wb_xbar_1ton;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_dat;
  logic              m_we;
  logic [DW/8-1:0]   m_sel;
  logic              m_cyc;
  logic              m_stb;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_o;
  logic              wbm_err_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic              wbs_we_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic [NS-1:0]     wbs_cyc_o;
  logic [NS-1:0]     wbs_stb_o;
  logic [NS*DW-1:0]  s_dat;
  logic [NS-1:0]     s_ack;
  logic              err_pending_o;
  logic [1:0]        err_cause_o;
  logic [AW-1:0]     err_adr_o;
  logic              err_clr;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  wb_xbar_1ton #(
    .NUM_SLAVES    (NS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SLAVE_BASE    ({32'h08000000, 32'h04000000, 32'h00000000}),
    .SLAVE_MASK    ({32'hFFFFFF00, 32'hFFFFE000, 32'hFFFF8000}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbm_adr_i    (m_adr),
    .wbm_dat_i    (m_dat),
    .wbm_we_i     (m_we),
    .wbm_sel_i    (m_sel),
    .wbm_cyc_i    (m_cyc),
    .wbm_stb_i    (m_stb),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_o    (wbm_ack_o),
    .wbm_err_o    (wbm_err_o),
    .wbs_adr_o    (wbs_adr_o),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_we_o     (wbs_we_o),
    .wbs_sel_o    (wbs_sel_o),
    .wbs_cyc_o    (wbs_cyc_o),
    .wbs_stb_o    (wbs_stb_o),
    .wbs_dat_i    (s_dat),
    .wbs_ack_i    (s_ack),
    .err_pending_o(err_pending_o),
    .err_cause_o  (err_cause_o),
    .err_adr_o    (err_adr_o),
    .err_clr_i    (err_clr)
  );

  // {ack, err, stb[2:0]}
  function automatic logic [4:0] flags();
    flags = {wbm_ack_o, wbm_err_o, wbs_stb_o};
  endfunction

  task automatic test_reset();
    rst = 1'b1; m_adr = 32'h04000010; m_dat = '0; m_we = 1'b0; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0; err_clr = 1'b0;
    s_dat = {32'h22222222, 32'hDEADBEEF, 32'h11111111};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    #1;
    n_total++; if ({flags(), wbs_cyc_o} !== 8'h00) begin n_bad++; $display("FAIL reset_flags got=%b exp=%b", {flags(), wbs_cyc_o}, 8'h00); end
    n_total++; if (wbm_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat got=%h exp=%h", wbm_dat_o, 32'h0); end
    n_total++; if ({err_pending_o, err_cause_o, err_adr_o} !== 35'h0) begin n_bad++; $display("FAIL reset_status got=%b/%b/%h exp=0/00/0", err_pending_o, err_cause_o, err_adr_o); end
  endtask

  task automatic test_read_s1();
    @(negedge clk); m_adr = 32'h04000010; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL rd1_T0 got=%b exp=%b", flags(), 5'b00000); end
    @(negedge clk); #1;
    n_total++; if (flags() !== 5'b00010) begin n_bad++; $display("FAIL rd1_T1 got=%b exp=%b", flags(), 5'b00010); end
    n_total++; if (wbs_adr_o !== 32'h04000010) begin n_bad++; $display("FAIL rd1_adr_bcast got=%h exp=%h", wbs_adr_o, 32'h04000010); end
    @(negedge clk); s_ack = 3'b010; #1;
    n_total++; if (flags() !== 5'b10010) begin n_bad++; $display("FAIL rd1_T2_ack got=%b exp=%b", flags(), 5'b10010); end
    n_total++; if (wbm_dat_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd1_dat got=%h exp=%h", wbm_dat_o, 32'hDEADBEEF); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL rd1_T3 got=%b exp=%b", flags(), 5'b00000); end
  endtask

  task automatic test_unmapped_write();
    @(negedge clk); m_adr = 32'h0C000000; m_we = 1'b1; m_dat = 32'hA5A5A5A5; m_cyc = 1'b1; m_stb = 1'b1; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL unm_T0 got=%b exp=%b", flags(), 5'b00000); end
    @(negedge clk); #1;
    n_total++; if (flags() !== 5'b01000) begin n_bad++; $display("FAIL unm_T1_err got=%b exp=%b", flags(), 5'b01000); end
    n_total++; if ({err_pending_o, err_cause_o} !== 3'b101) begin n_bad++; $display("FAIL unm_status got=%b exp=%b", {err_pending_o, err_cause_o}, 3'b101); end
    n_total++; if (err_adr_o !== 32'h0C000000) begin n_bad++; $display("FAIL unm_adr got=%h exp=%h", err_adr_o, 32'h0C000000); end
    n_total++; if (wbm_dat_o !== 32'h0) begin n_bad++; $display("FAIL unm_dat got=%h exp=%h", wbm_dat_o, 32'h0); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; err_clr = 1'b1; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL unm_T2_one_cycle got=%b exp=%b", flags(), 5'b00000); end
    @(negedge clk); err_clr = 1'b0; #1;
    n_total++; if (err_pending_o !== 1'b0) begin n_bad++; $display("FAIL unm_clear got=%b exp=%b", err_pending_o, 1'b0); end
  endtask

  task automatic test_timeout();
    @(negedge clk); m_adr = 32'h08000004; m_cyc = 1'b1; m_stb = 1'b1; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL tmo_T0 got=%b exp=%b", flags(), 5'b00000); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      n_total++; if (flags() !== 5'b00100) begin n_bad++; $display("FAIL tmo_stb_T%0d got=%b exp=%b", k, flags(), 5'b00100); end
    end
    @(negedge clk); #1;
    n_total++; if (flags() !== 5'b01000) begin n_bad++; $display("FAIL tmo_T9_err got=%b exp=%b", flags(), 5'b01000); end
    n_total++; if ({err_pending_o, err_cause_o} !== 3'b110) begin n_bad++; $display("FAIL tmo_status got=%b exp=%b", {err_pending_o, err_cause_o}, 3'b110); end
    n_total++; if (err_adr_o !== 32'h08000004) begin n_bad++; $display("FAIL tmo_adr got=%h exp=%h", err_adr_o, 32'h08000004); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL tmo_T10 got=%b exp=%b", flags(), 5'b00000); end
  endtask

  task automatic test_err_clr_collision();
    // Pending is still set from the timeout; clear and a fresh fault land in the same cycle.
    @(negedge clk); m_adr = 32'h10000000; m_cyc = 1'b1; m_stb = 1'b1; err_clr = 1'b1; #1;
    @(negedge clk); err_clr = 1'b0; #1;
    n_total++; if (flags() !== 5'b01000) begin n_bad++; $display("FAIL col_err got=%b exp=%b", flags(), 5'b01000); end
    n_total++; if ({err_pending_o, err_cause_o} !== 3'b101) begin n_bad++; $display("FAIL col_status got=%b exp=%b", {err_pending_o, err_cause_o}, 3'b101); end
    n_total++; if (err_adr_o !== 32'h10000000) begin n_bad++; $display("FAIL col_adr got=%h exp=%h", err_adr_o, 32'h10000000); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    n_total++; if (err_pending_o !== 1'b0) begin n_bad++; $display("FAIL col_lone_clear got=%b exp=%b", err_pending_o, 1'b0); end
  endtask

  task automatic test_abort_stray();
    @(negedge clk); m_adr = 32'h00000040; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); #1;
    n_total++; if ({wbs_cyc_o, wbs_stb_o} !== 6'b001001) begin n_bad++; $display("FAIL abort_busy got=%b exp=%b", {wbs_cyc_o, wbs_stb_o}, 6'b001001); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; s_ack = 3'b001; #1;
    n_total++; if ({flags(), wbs_cyc_o} !== 8'h00) begin n_bad++; $display("FAIL abort_drop got=%b exp=%b", {flags(), wbs_cyc_o}, 8'h00); end
    @(negedge clk); s_ack = '0; #1;
    n_total++; if ({flags(), err_pending_o} !== 6'b000000) begin n_bad++; $display("FAIL abort_after got=%b exp=%b", {flags(), err_pending_o}, 6'b000000); end
    @(negedge clk); m_adr = 32'h04000020; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); s_ack = 3'b001; #1;
    n_total++; if (flags() !== 5'b00010) begin n_bad++; $display("FAIL stray_ack got=%b exp=%b", flags(), 5'b00010); end
    @(negedge clk); s_ack = 3'b010; s_dat = {32'h22222222, 32'h12345678, 32'h11111111}; #1;
    n_total++; if (flags() !== 5'b10010) begin n_bad++; $display("FAIL stray_real_ack got=%b exp=%b", flags(), 5'b10010); end
    n_total++; if (wbm_dat_o !== 32'h12345678) begin n_bad++; $display("FAIL stray_dat got=%h exp=%h", wbm_dat_o, 32'h12345678); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
  endtask

  task automatic test_reset_mid();
    // Leave a sticky fault behind so the reset has status to clear.
    @(negedge clk); m_adr = 32'h0C000000; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk); m_adr = 32'h04000000; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); #1;
    n_total++; if ({flags(), err_pending_o} !== 6'b000101) begin n_bad++; $display("FAIL rstm_busy got=%b exp=%b", {flags(), err_pending_o}, 6'b000101); end
    @(negedge clk); rst = 1'b1; s_ack = 3'b010; #1;
    n_total++; if (wbm_ack_o !== 1'b0) begin n_bad++; $display("FAIL rstm_ack_dropped got=%b exp=%b", wbm_ack_o, 1'b0); end
    @(negedge clk); rst = 1'b0; s_ack = '0; m_adr = 32'h00000100; #1;
    n_total++; if ({flags(), wbs_cyc_o} !== 8'h00) begin n_bad++; $display("FAIL rstm_idle got=%b exp=%b", {flags(), wbs_cyc_o}, 8'h00); end
    n_total++; if (wbm_dat_o !== 32'h0) begin n_bad++; $display("FAIL rstm_dat got=%h exp=%h", wbm_dat_o, 32'h0); end
    n_total++; if ({err_pending_o, err_cause_o, err_adr_o} !== 35'h0) begin n_bad++; $display("FAIL rstm_status got=%b/%b/%h exp=0/00/0", err_pending_o, err_cause_o, err_adr_o); end
    @(negedge clk); s_ack = 3'b001; s_dat = {32'h22222222, 32'h12345678, 32'hCAFE0100}; #1;
    n_total++; if (flags() !== 5'b10001) begin n_bad++; $display("FAIL rstm_next_ack got=%b exp=%b", flags(), 5'b10001); end
    n_total++; if (wbm_dat_o !== 32'hCAFE0100) begin n_bad++; $display("FAIL rstm_next_dat got=%h exp=%h", wbm_dat_o, 32'hCAFE0100); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); m_adr = 32'h00000200; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); s_ack = 3'b001; #1;
    n_total++; if (flags() !== 5'b10001) begin n_bad++; $display("FAIL b2b_ack0 got=%b exp=%b", flags(), 5'b10001); end
    @(negedge clk); s_ack = '0; m_adr = 32'h04000100; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL b2b_gap got=%b exp=%b", flags(), 5'b00000); end
    @(negedge clk); s_ack = 3'b010; #1;
    n_total++; if (flags() !== 5'b10010) begin n_bad++; $display("FAIL b2b_ack1 got=%b exp=%b", flags(), 5'b10010); end
    n_total++; if (wbm_dat_o !== 32'h12345678) begin n_bad++; $display("FAIL b2b_dat1 got=%h exp=%h", wbm_dat_o, 32'h12345678); end
    @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; #1;
    n_total++; if (flags() !== 5'b00000) begin n_bad++; $display("FAIL b2b_end got=%b exp=%b", flags(), 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_read_s1();
    test_unmapped_write();
    test_timeout();
    test_err_clr_collision();
    test_abort_stray();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
